// File: rtl/id_al_queue.sv
// Decoded-instruction queue between ID and the allocation stage.
// Circular buffer that accepts up to four compacted writes and presents the four oldest entries.
module id_al_queue #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 66
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               dcd_inst1_in,
    input  logic [W-1:0]               dcd_inst2_in,
    input  logic [W-1:0]               dcd_inst3_in,
    input  logic [W-1:0]               dcd_inst4_in,
    input  logic [3:0]                 dcd_vld_in,
    input  logic                       mis_pred_in,
    input  logic                       al_rdy_in,
    output logic [W-1:0]               inst1_out_to_AL,
    output logic [W-1:0]               inst2_out_to_AL,
    output logic [W-1:0]               inst3_out_to_AL,
    output logic [W-1:0]               inst4_out_to_AL,
    output logic [3:0]                 vld_out_to_AL,
    output logic                       stll_out_to_ID,
    output logic [$clog2(DEPTH):0]     occ_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [W-1:0]  in_inst  [4];
    logic [3:0]    slot_vld;
    logic [2:0]    wr_off   [4];
    logic [AW-1:0] wr_addr  [4];
    logic [AW-1:0] rd_addr  [4];
    logic [W-1:0]  out_inst [4];
    logic [3:0]    out_vld;
    logic [2:0]    num_wr;
    logic [2:0]    num_rd;
    logic          wr_en;

    assign in_inst[0] = dcd_inst1_in;
    assign in_inst[1] = dcd_inst2_in;
    assign in_inst[2] = dcd_inst3_in;
    assign in_inst[3] = dcd_inst4_in;

    // Index 0 is slot 1 (oldest), which arrives on dcd_vld_in[3].
    assign slot_vld = {dcd_vld_in[0], dcd_vld_in[1], dcd_vld_in[2], dcd_vld_in[3]};

    assign stll_out_to_ID = (count_q > CW'(DEPTH - 4));
    assign wr_en          = !stll_out_to_ID && !mis_pred_in;

    // Each valid slot lands at tail plus the number of valid slots older than it.
    always_comb begin
        wr_off[0] = 3'd0;
        for (int i = 1; i < 4; i++) begin
            wr_off[i] = wr_off[i-1] + {2'b00, slot_vld[i-1]};
        end
        num_wr = wr_off[3] + {2'b00, slot_vld[3]};
        for (int i = 0; i < 4; i++) begin
            wr_addr[i] = tail_q + AW'(wr_off[i]);
        end
    end

    always_comb begin
        num_rd = 3'd0;
        if (al_rdy_in && !mis_pred_in) begin
            num_rd = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mis_pred_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(num_rd);
            count_d = count_q - CW'(num_rd);
            if (wr_en) begin
                tail_d  = tail_q + AW'(num_wr);
                count_d = count_q + CW'(num_wr) - CW'(num_rd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally left unreset; validity comes from count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && slot_vld[i]) begin
                mem[wr_addr[i]] <= in_inst[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rd_addr[i]  = head_q + AW'(i);
            out_vld[i]  = !mis_pred_in && (count_q > CW'(i));
            out_inst[i] = out_vld[i] ? mem[rd_addr[i]] : '0;
        end
    end

    assign inst1_out_to_AL = out_inst[0];
    assign inst2_out_to_AL = out_inst[1];
    assign inst3_out_to_AL = out_inst[2];
    assign inst4_out_to_AL = out_inst[3];
    assign vld_out_to_AL   = {out_vld[0], out_vld[1], out_vld[2], out_vld[3]};
    assign occ_out         = count_q;

endmodule

// File: tb/tb_id_al_queue.sv
// Directed self-checking bench for id_al_queue (DEPTH=16, W=66).
module tb_id_al_queue;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned W     = 66;

    logic         clk;
    logic         rst;
    logic [W-1:0] i1, i2, i3, i4;
    logic [3:0]   vin;
    logic         mp;
    logic         rdy;
    logic [W-1:0] o1, o2, o3, o4;
    logic [3:0]   vout;
    logic         stll;
    logic [4:0]   occ;

    int errors = 0;
    int checks = 0;

    id_al_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .dcd_inst1_in    (i1),
        .dcd_inst2_in    (i2),
        .dcd_inst3_in    (i3),
        .dcd_inst4_in    (i4),
        .dcd_vld_in      (vin),
        .mis_pred_in     (mp),
        .al_rdy_in       (rdy),
        .inst1_out_to_AL (o1),
        .inst2_out_to_AL (o2),
        .inst3_out_to_AL (o3),
        .inst4_out_to_AL (o4),
        .vld_out_to_AL   (vout),
        .stll_out_to_ID  (stll),
        .occ_out         (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input int n);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = 32'(n) ^ 32'h5A5A_5A5A;
        hi = 32'hC0DE_0000 + 32'(n);
        return {2'b10, hi, lo};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slots(input string tag, input logic [3:0] v, input int a, input int b,
                             input int c, input int d);
        chk({tag, " vld"}, W'(vout), W'(v));
        chk({tag, " s1"}, o1, v[3] ? mk(a) : '0);
        chk({tag, " s2"}, o2, v[2] ? mk(b) : '0);
        chk({tag, " s3"}, o3, v[1] ? mk(c) : '0);
        chk({tag, " s4"}, o4, v[0] ? mk(d) : '0);
    endtask

    // Apply one cycle of stimulus, then return inputs to idle and sample 1ns after the edge.
    task automatic cyc(input logic [3:0] v, input int a, input int b, input int c, input int d,
                       input logic r, input logic m);
        vin = v; i1 = mk(a); i2 = mk(b); i3 = mk(c); i4 = mk(d); rdy = r; mp = m;
        @(posedge clk);
        #1;
        vin = 4'b0000; rdy = 1'b0; mp = 1'b0;
        i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        #1;
    endtask

    initial begin
        rst = 1'b0; vin = 4'b0000; mp = 1'b0; rdy = 1'b0;
        i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        #12;
        chk("reset occ", W'(occ), W'(0));
        chk("reset stll", W'(stll), W'(0));
        chk_slots("reset", 4'b0000, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);

        // Four valid writes, no read
        cyc(4'b1111, 1, 2, 3, 4, 1'b0, 1'b0);
        chk("abcd occ", W'(occ), W'(4));
        chk_slots("abcd", 4'b1111, 1, 2, 3, 4);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("drain1 occ", W'(occ), W'(0));

        // Sparse valid mask is compacted
        cyc(4'b1010, 10, 11, 12, 13, 1'b0, 1'b0);
        chk("pqrs occ", W'(occ), W'(2));
        chk_slots("pqrs", 4'b1100, 10, 12, 0, 0);

        // Read and write in the same cycle
        cyc(4'b1111, 20, 21, 22, 23, 1'b1, 1'b0);
        chk("rw occ", W'(occ), W'(4));
        chk_slots("rw", 4'b1111, 20, 21, 22, 23);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);

        // Move head to 14, then store 10 entries across the wrap
        cyc(4'b1111, 30, 31, 32, 33, 1'b0, 1'b0);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("h14 occ", W'(occ), W'(0));
        cyc(4'b1111, 40, 41, 42, 43, 1'b0, 1'b0);
        cyc(4'b1111, 44, 45, 46, 47, 1'b0, 1'b0);
        cyc(4'b1100, 48, 49, 0, 0, 1'b0, 1'b0);
        chk("wrap occ10", W'(occ), W'(10));
        chk_slots("wrap g1", 4'b1111, 40, 41, 42, 43);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("wrap occ6", W'(occ), W'(6));
        chk_slots("wrap g2", 4'b1111, 44, 45, 46, 47);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("wrap occ2", W'(occ), W'(2));
        chk_slots("wrap g3", 4'b1100, 48, 49, 0, 0);
        cyc(4'b0000, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("wrap occ0", W'(occ), W'(0));

        // Fill to full; stall only once count exceeds 12
        cyc(4'b1111, 50, 51, 52, 53, 1'b0, 1'b0);
        cyc(4'b1111, 54, 55, 56, 57, 1'b0, 1'b0);
        cyc(4'b1111, 58, 59, 60, 61, 1'b0, 1'b0);
        chk("fill occ12", W'(occ), W'(12));
        chk("fill stll12", W'(stll), W'(0));
        cyc(4'b1111, 62, 63, 64, 65, 1'b0, 1'b0);
        chk("fill occ16", W'(occ), W'(16));
        chk("fill stll16", W'(stll), W'(1));
        cyc(4'b1111, 70, 71, 72, 73, 1'b0, 1'b0);
        chk("full drop occ", W'(occ), W'(16));
        chk_slots("full", 4'b1111, 50, 51, 52, 53);

        // Flush from full: valid drops combinationally
        mp = 1'b1;
        #1;
        chk("flush comb vld", W'(vout), W'(0));
        cyc(4'b0000, 0, 0, 0, 0, 1'b0, 1'b1);
        chk("flush occ", W'(occ), W'(0));
        chk("flush stll", W'(stll), W'(0));

        // Flush with concurrent read and write at occ 9
        cyc(4'b1111, 80, 81, 82, 83, 1'b0, 1'b0);
        cyc(4'b1111, 84, 85, 86, 87, 1'b0, 1'b0);
        cyc(4'b1000, 88, 0, 0, 0, 1'b0, 1'b0);
        chk("occ9", W'(occ), W'(9));
        vin = 4'b1111; i1 = mk(90); i2 = mk(91); i3 = mk(92); i4 = mk(93); rdy = 1'b1; mp = 1'b1;
        #1;
        chk("mp9 comb vld", W'(vout), W'(0));
        cyc(4'b1111, 90, 91, 92, 93, 1'b1, 1'b1);
        chk("mp9 occ", W'(occ), W'(0));
        chk("mp9 stll", W'(stll), W'(0));
        chk_slots("mp9", 4'b0000, 0, 0, 0, 0);
        cyc(4'b0100, 0, 95, 0, 0, 1'b0, 1'b0);
        chk("post flush occ", W'(occ), W'(1));
        chk_slots("post flush", 4'b1000, 95, 0, 0, 0);

        // Asynchronous reset mid-operation
        cyc(4'b1111, 100, 101, 102, 103, 1'b0, 1'b0);
        chk("pre rst occ", W'(occ), W'(5));
        #2;
        rst = 1'b0;
        #1;
        chk("async rst occ", W'(occ), W'(0));
        chk_slots("async rst", 4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b0001, 0, 0, 0, 110, 1'b0, 1'b0);
        chk("after rst occ", W'(occ), W'(1));
        chk_slots("after rst", 4'b1000, 110, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
